// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side signals of uart_tx_arbiter, grouped for port binding.
// Handshake: a byte moves when valid && ready in the same cycle; valid never waits on ready.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   i_req_valid;
   logic [8*N_REQ-1:0] i_req_data;
   logic [N_REQ-1:0]   i_req_last;
   logic [N_REQ-1:0]   o_req_ready;
   logic [7:0]         o_tx_data;
   logic               o_tx_valid;
   logic               i_tx_ready;
   logic [N_REQ-1:0]   o_grant;
   logic               o_busy;
   logic               o_timeout;
   logic               o_dbg_locked;

   modport master (
      output i_req_valid, i_req_data, i_req_last, i_tx_ready,
      input  o_req_ready, o_tx_data, o_tx_valid, o_grant, o_busy, o_timeout, o_dbg_locked
   );

   modport slave (
      input  i_req_valid, i_req_data, i_req_last, i_tx_ready,
      output o_req_ready, o_tx_data, o_tx_valid, o_grant, o_busy, o_timeout, o_dbg_locked
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart_tx between N_REQ byte streams,
// with an idle-timeout that revokes stalled owners and one registered output stage.
module uart_tx_arbiter #(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic               i_clk,
   input logic               i_rst,
   uart_tx_arbiter_if.slave  bus
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [IW-1:0]    last_g_q, last_g_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_valid_q, tx_valid_d;
   logic             timeout_q, timeout_d;

   logic             owner_valid, owner_last, out_free, accept, stall_expire, any_valid;
   logic [7:0]       owner_data;
   logic [IW-1:0]    cand, pick_idx;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         last_g_q   <= IW'(N_REQ - 1);
         cnt_q      <= '0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_g_q   <= last_g_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin : owner_mux
      owner_valid = 1'b0;
      owner_last  = 1'b0;
      owner_data  = 8'h00;
      for (int k = 0; k < N_REQ; k++) begin
         if (grant_q[k]) begin
            owner_valid = bus.i_req_valid[k];
            owner_last  = bus.i_req_last[k];
            owner_data  = bus.i_req_data[8*k +: 8];
         end
      end
   end

   // Search starts one past the previous winner so every requester gets a turn.
   always_comb begin : rr_pick
      any_valid = 1'b0;
      pick_idx  = last_g_q;
      cand      = last_g_q;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = IW'((int'(last_g_q) + i) % N_REQ);
         if (!any_valid && bus.i_req_valid[cand]) begin
            any_valid = 1'b1;
            pick_idx  = cand;
         end
      end
   end

   assign out_free     = !tx_valid_q || bus.i_tx_ready;
   assign accept       = (state_q == ST_LOCKED) && owner_valid && out_free;
   assign stall_expire = (TIMEOUT_CYCLES != 0) && (state_q == ST_LOCKED) && !owner_valid &&
                         (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin : next_state
      state_d   = state_q;
      grant_d   = grant_q;
      last_g_d  = last_g_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (any_valid) begin
               state_d  = ST_LOCKED;
               grant_d  = N_REQ'(1) << pick_idx;
               last_g_d = pick_idx;
            end
         end
         ST_LOCKED: begin
            if (accept && owner_last) begin
               state_d = ST_IDLE;
               grant_d = '0;
               cnt_d   = '0;
            end else if (stall_expire) begin
               state_d   = ST_IDLE;
               grant_d   = '0;
               cnt_d     = '0;
               timeout_d = 1'b1;
            end else if (owner_valid || (TIMEOUT_CYCLES == 0)) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // A load in the same cycle as a drain wins, keeping valid high with the new byte.
   always_comb begin : out_stage
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      if (tx_valid_q && bus.i_tx_ready) tx_valid_d = 1'b0;
      if (accept) begin
         tx_valid_d = 1'b1;
         tx_data_d  = owner_data;
      end
   end

   always_comb begin : outputs
      bus.o_req_ready  = ((state_q == ST_LOCKED) && out_free) ? grant_q : '0;
      bus.o_busy       = (state_q == ST_LOCKED) || tx_valid_q;
      bus.o_grant      = grant_q;
      bus.o_tx_data    = tx_data_q;
      bus.o_tx_valid   = tx_valid_q;
      bus.o_timeout    = timeout_q;
      bus.o_dbg_locked = (state_q == ST_LOCKED);
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, hand-written corner sequences,
// and message-level stream runs checked against a round-robin reference model.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int TO = 16;

   logic i_clk = 1'b0;
   logic i_rst;
   always #5 i_clk = ~i_clk;

   uart_tx_arbiter_if #(.N_REQ(N)) bus ();

   uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0]  v;
      logic [31:0] d;
      logic [3:0]  l;
      logic        r;
      logic [3:0]  e_grant;
      logic        e_txv;
      logic [7:0]  e_data;
      logic [3:0]  e_ready;
      logic        e_busy;
   } vec_t;

   vec_t        tbl[5];
   logic [8:0]  src_mem[N][16];
   int          src_len[N];
   int          ptr[N];
   logic [7:0]  exp_q[$];
   int          order_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l, input logic r);
      bus.i_req_valid = v;
      bus.i_req_data  = d;
      bus.i_req_last  = l;
      bus.i_tx_ready  = r;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      drive(4'b0, 32'h0, 4'b0, 1'b1);
      tick();
      tick();
      i_rst = 1'b0;
   endtask

   task automatic run_stream(input bit rnd);
      logic [3:0]  pv, pg, g, v, l, acc;
      logic [31:0] d;
      logic        plast, ptxv, prdy, r;
      logic [7:0]  pdata;
      int          mlast, cyc, w;
      int          stall[N];
      bit          done;
      pv = '0; pg = '0; plast = 1'b0; ptxv = 1'b0; prdy = 1'b0; pdata = 8'h00;
      mlast = N - 1;
      cyc = 0;
      done = 1'b0;
      exp_q.delete();
      order_q.delete();
      for (int k = 0; k < N; k++) begin
         ptr[k] = 0;
         stall[k] = 0;
      end
      while (!done && cyc < 3000) begin
         g = bus.o_grant;
         if (pg == 4'b0) begin
            if (pv != 4'b0) begin
               w = 0;
               for (int i = N; i >= 1; i--) if (pv[(mlast + i) % N]) w = (mlast + i) % N;
               chk("rr_grant", g, 32'(1 << w));
               mlast = w;
               order_q.push_back(w);
               for (int p = ptr[w]; p < src_len[w]; p++) begin
                  exp_q.push_back(src_mem[w][p][7:0]);
                  if (src_mem[w][p][8]) break;
               end
            end else begin
               chk("idle_grant", g, 0);
            end
         end else begin
            chk("hold_grant", g, plast ? 4'b0 : pg);
         end
         if (ptxv && !prdy) begin
            chk("hold_valid", bus.o_tx_valid, 1);
            chk("hold_data", bus.o_tx_data, pdata);
         end
         v = '0; d = '0; l = '0;
         for (int k = 0; k < N; k++) begin
            if (ptr[k] < src_len[k]) begin
               if (!rnd || stall[k] >= 6 || $urandom_range(0, 3) != 0) v[k] = 1'b1;
               stall[k] = v[k] ? 0 : stall[k] + 1;
               d[8*k +: 8] = src_mem[k][ptr[k]][7:0];
               l[k] = src_mem[k][ptr[k]][8];
            end
         end
         r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         drive(v, d, l, r);
         #1;
         acc = v & bus.o_req_ready;
         if (bus.o_tx_valid && r) begin
            if (exp_q.size() == 0) chk("tx_unexpected", 1, 0);
            else chk("tx_byte", bus.o_tx_data, exp_q.pop_front());
         end
         plast = 1'b0;
         for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
               if (src_mem[k][ptr[k]][8]) plast = 1'b1;
               ptr[k]++;
            end
         end
         pv = v; pg = g; ptxv = bus.o_tx_valid; prdy = r; pdata = bus.o_tx_data;
         done = (exp_q.size() == 0);
         for (int k = 0; k < N; k++) if (ptr[k] < src_len[k]) done = 1'b0;
         tick();
         cyc++;
      end
      chk("stream_done", done, 1);
      drive(4'b0, 32'h0, 4'b0, 1'b1);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_ord[5];
      int nm, p, len;
      exp_ord = '{0, 1, 2, 3, 0};

      tbl[0] = '{4'b0100, 32'h0041_0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
      tbl[1] = '{4'b0100, 32'h0041_0000, 4'b0000, 1'b1, 4'b0100, 1'b0, 8'h00, 4'b0100, 1'b1};
      tbl[2] = '{4'b0100, 32'h0042_0000, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h41, 4'b0100, 1'b1};
      tbl[3] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h42, 4'b0000, 1'b1};
      tbl[4] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h42, 4'b0000, 1'b0};

      i_rst = 1'b1;
      drive(4'b0, 32'h0, 4'b0, 1'b1);
      tick();
      tick();
      chk("rst_grant", bus.o_grant, 0);
      chk("rst_txv", bus.o_tx_valid, 0);
      chk("rst_data", bus.o_tx_data, 0);
      chk("rst_timeout", bus.o_timeout, 0);
      chk("rst_busy", bus.o_busy, 0);
      i_rst = 1'b0;

      // requester 2 sends 0x41, 0x42(last)
      for (int i = 0; i < 5; i++) begin
         chk("vec_grant", bus.o_grant, tbl[i].e_grant);
         chk("vec_txv", bus.o_tx_valid, tbl[i].e_txv);
         chk("vec_data", bus.o_tx_data, tbl[i].e_data);
         chk("vec_timeout", bus.o_timeout, 0);
         drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
         #1;
         chk("vec_ready", bus.o_req_ready, tbl[i].e_ready);
         chk("vec_busy", bus.o_busy, tbl[i].e_busy);
         tick();
      end

      // stalled uart: 0x55 must hold for 20 cycles, next byte taken when ready rises
      drive(4'b0010, 32'h0000_5500, 4'b0000, 1'b1);
      tick();
      chk("stall_grant", bus.o_grant, 4'b0010);
      chk("stall_ready0", bus.o_req_ready, 4'b0010);
      tick();
      drive(4'b0010, 32'h0000_6600, 4'b0010, 1'b0);
      #1;
      for (int i = 0; i < 20; i++) begin
         chk("stall_data", bus.o_tx_data, 8'h55);
         chk("stall_txv", bus.o_tx_valid, 1);
         chk("stall_ready", bus.o_req_ready, 0);
         tick();
      end
      bus.i_tx_ready = 1'b1;
      #1;
      chk("stall_release_ready", bus.o_req_ready, 4'b0010);
      tick();
      chk("stall_next_data", bus.o_tx_data, 8'h66);
      chk("stall_next_txv", bus.o_tx_valid, 1);
      chk("stall_rel_grant", bus.o_grant, 0);
      drive(4'b0, 32'h0, 4'b0, 1'b1);
      tick();
      chk("stall_drained", bus.o_tx_valid, 0);
      chk("stall_busy", bus.o_busy, 0);

      // owner 1 stalls mid-message, requester 3 waits
      drive(4'b0010, 32'h0000_1000, 4'b0000, 1'b1);
      tick();
      chk("to_grant", bus.o_grant, 4'b0010);
      tick();
      chk("to_byte", bus.o_tx_data, 8'h10);
      drive(4'b1000, 32'h3300_0000, 4'b1000, 1'b1);
      for (int i = 0; i < TO; i++) begin
         chk("to_early", bus.o_timeout, 0);
         chk("to_held", bus.o_grant, 4'b0010);
         tick();
      end
      chk("to_pulse", bus.o_timeout, 1);
      chk("to_grant_clr", bus.o_grant, 0);
      tick();
      chk("to_pulse_end", bus.o_timeout, 0);
      chk("to_next_owner", bus.o_grant, 4'b1000);
      chk("to_next_ready", bus.o_req_ready, 4'b1000);
      tick();
      chk("to_next_data", bus.o_tx_data, 8'h33);
      drive(4'b0, 32'h0, 4'b0, 1'b1);
      tick();

      // owner valid returns exactly on the last counted stall cycle
      drive(4'b0001, 32'h0000_0020, 4'b0000, 1'b1);
      tick();
      chk("cnt_grant", bus.o_grant, 4'b0001);
      tick();
      drive(4'b0, 32'h0, 4'b0, 1'b1);
      for (int i = 0; i < TO - 1; i++) begin
         chk("cnt_no_to", bus.o_timeout, 0);
         tick();
      end
      drive(4'b0001, 32'h0000_0021, 4'b0000, 1'b1);
      #1;
      chk("cnt_rescue_ready", bus.o_req_ready, 4'b0001);
      tick();
      drive(4'b0, 32'h0, 4'b0, 1'b1);
      for (int i = 0; i < TO; i++) begin
         chk("cnt_cleared", bus.o_timeout, 0);
         chk("cnt_held", bus.o_grant, 4'b0001);
         tick();
      end
      chk("cnt_second_to", bus.o_timeout, 1);
      tick();

      // reset mid-message with a byte in the output register
      drive(4'b0010, 32'h0000_7700, 4'b0000, 1'b0);
      tick();
      chk("rm_grant", bus.o_grant, 4'b0010);
      chk("rm_ready", bus.o_req_ready, 4'b0010);
      tick();
      chk("rm_txv", bus.o_tx_valid, 1);
      i_rst = 1'b1;
      tick();
      chk("rm_txv_clr", bus.o_tx_valid, 0);
      chk("rm_grant_clr", bus.o_grant, 0);
      chk("rm_timeout", bus.o_timeout, 0);
      chk("rm_data_clr", bus.o_tx_data, 0);
      i_rst = 1'b0;
      drive(4'b1001, 32'h0300_0001, 4'b0000, 1'b1);
      tick();
      chk("rm_prio0", bus.o_grant, 4'b0001);

      // all requesters continuously valid with 2-byte messages
      do_reset();
      for (int k = 0; k < N; k++) begin
         src_len[k] = (k == 0) ? 4 : 2;
         for (int q = 0; q < src_len[k]; q++)
            src_mem[k][q] = {1'(q % 2), 8'(8'hA0 + 16 * k + q)};
      end
      run_stream(1'b0);
      for (int i = 0; i < 5; i++)
         chk("rr_order", (i < order_q.size()) ? order_q[i] : -1, exp_ord[i]);

      // randomized message streams
      for (int run = 0; run < 3; run++) begin
         do_reset();
         for (int k = 0; k < N; k++) begin
            nm = $urandom_range(2, 5);
            p = 0;
            for (int m = 0; m < nm; m++) begin
               len = $urandom_range(1, 3);
               for (int b = 0; b < len; b++) begin
                  src_mem[k][p] = {1'(b == len - 1), 8'($urandom_range(0, 255))};
                  p++;
               end
            end
            src_len[k] = p;
         end
         run_stream(1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
